tdpu_feeder: RTL

TDPU_FEEDER -- requirements
Module: tdpu_feeder

---
 rtl/tdpu_feeder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tdpu_feeder.sv
// Feeder for the ternary vector core: loads one weight vector, streams activation vectors with
// credit-based flow control, and buffers the core's results in a first-word-fall-through FIFO.
// Weight encoding (2 bits per lane): W_ZERO=2'b00, W_POS=2'b01, W_NEG=2'b11.
module tdpu_feeder #(
    parameter int LEN        = 16,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [15:0]                  i_num_vec,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err,
    input  logic [2*LEN-1:0]             i_weight,
    input  logic                         i_weight_valid,
    output logic                         o_weight_ready,
    input  logic [LEN*DATA_WIDTH-1:0]    i_act,
    input  logic                         i_act_valid,
    output logic                         o_act_ready,
    output logic                         o_load_weight,
    output logic [2*LEN-1:0]             o_weight,
    output logic                         o_data_valid,
    output logic [LEN*DATA_WIDTH-1:0]    o_data,
    input  logic                         i_core_ready,
    input  logic signed [31:0]           i_core_result,
    output logic                         o_res_valid,
    output logic signed [31:0]           o_res_data,
    input  logic                         i_res_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [15:0]     num_vec, issued, received;
    logic [CW-1:0]   inflight, fifo_count;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     mem [FIFO_DEPTH];

    logic start_job, weight_hs, credit_ok, issue, ret_ok, ret_bad;
    logic fifo_full, fifo_empty, push, pop, overflow;

    // Credit uses registered occupancy only, so a pop in this cycle does not free a slot yet.
    assign start_job  = (state == IDLE) && i_start;
    assign weight_hs  = (state == LOAD_W) && i_weight_valid;
    assign credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
    assign issue      = o_act_ready && i_act_valid;
    assign ret_ok     = i_core_ready && (inflight != '0);
    assign ret_bad    = i_core_ready && (inflight == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !fifo_empty && i_res_ready;
    assign push       = ret_ok && (!fifo_full || pop);
    assign overflow   = ret_ok && fifo_full && !pop;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = (i_num_vec == 16'd0) ? DONE : LOAD_W;
            LOAD_W:  if (i_weight_valid) state_next = STREAM;
            STREAM:  if (issued == num_vec) state_next = DRAIN;
            DRAIN:   if (received == num_vec) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy         = (state != IDLE);
        o_done         = (state == DONE);
        o_weight_ready = (state == LOAD_W);
        o_act_ready    = (state == STREAM) && (issued < num_vec) && credit_ok;
        o_load_weight  = weight_hs;
        o_weight       = weight_hs ? i_weight : '0;
        o_data_valid   = issue;
        o_data         = issue ? i_act : '0;
        o_res_valid    = !fifo_empty;
        o_res_data     = fifo_empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_vec  <= '0;
            issued   <= '0;
            received <= '0;
            inflight <= '0;
            o_err    <= 1'b0;
        end else begin
            if (start_job) begin
                num_vec  <= i_num_vec;
                issued   <= '0;
                received <= '0;
            end else begin
                if (issue)  issued   <= issued + 16'd1;
                if (ret_ok) received <= received + 16'd1;
            end
            case ({issue, ret_ok})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            if (ret_bad || overflow) o_err <= 1'b1;
            else if (start_job)      o_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_core_result;
    end

endmodule
